blood_test_scheduler: RTL and testbench

- Time-shares one blood abnormality detector datapath (inputs: 4-bit pH, 3-bit blood type; output: 1-bit abnormality) between NUM_PATIENTS bedside sample sources.
- Accepts samples through valid/ready handshakes and picks a requester round-robin.
- Presents the sample to the detector, captures the verdict and publishes a tagged result.
- Keeps a per-patient consecutive-abnormal streak and raises a sticky alarm once the streak is confirmed.

---
 rtl/blood_sched_pkg.sv | 17 +
 rtl/blood_test_scheduler_rr_arbiter.sv | 38 +++
 rtl/blood_test_scheduler.sv | 143 ++++++++++++++
 tb/tb_blood_test_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/blood_sched_pkg.sv
// Shared types and widths for the blood test scheduler and its detector interface.
package blood_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int PH_W   = 4;
    localparam int TYPE_W = 3;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blood_test_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins, wrapping modulo N.
module rr_arbiter
    import blood_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idxWidth(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int          w_cand;
    logic [IW-1:0] w_candIdx;

    always_comb begin
        o_grant   = '0;
        o_idx     = '0;
        o_any     = 1'b0;
        w_cand    = 0;
        w_candIdx = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = 32'(i_ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            w_candIdx = IW'(w_cand);
            if (!o_any && i_req[w_candIdx]) begin
                o_grant[w_candIdx] = 1'b1;
                o_idx              = w_candIdx;
                o_any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blood_test_scheduler.sv
// Time-shares one abnormality detector between NUM_PATIENTS sample sources,
// tracking per-patient abnormal streaks and raising sticky alarms.
module blood_test_scheduler
    import blood_sched_pkg::*;
#(
    parameter int NUM_PATIENTS  = 4,
    parameter int CONFIRM_COUNT = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PATIENTS-1:0]           sample_valid,
    input  logic [PH_W*NUM_PATIENTS-1:0]      sample_ph,
    input  logic [TYPE_W*NUM_PATIENTS-1:0]    sample_type,
    output logic [NUM_PATIENTS-1:0]           sample_ready,
    output logic [PH_W-1:0]                   det_ph,
    output logic [TYPE_W-1:0]                 det_type,
    input  logic                              det_abnormal,
    output logic                              result_valid,
    output logic [$clog2(NUM_PATIENTS)-1:0]   result_patient,
    output logic                              result_abnormal,
    output logic [NUM_PATIENTS-1:0]           alarm,
    input  logic [NUM_PATIENTS-1:0]           alarm_clear,
    output logic                              busy
);

    localparam int IW = $clog2(NUM_PATIENTS);
    localparam int CW = $clog2(CONFIRM_COUNT + 1);
    localparam logic [CW-1:0] CONF = CW'(CONFIRM_COUNT);

    state_t              r_state;
    state_t              w_nextState;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_grantIdx;
    logic [PH_W-1:0]     r_detPh;
    logic [TYPE_W-1:0]   r_detType;
    logic                r_resultAbnormal;
    logic [CW-1:0]       r_streak [NUM_PATIENTS];
    logic [NUM_PATIENTS-1:0] r_alarm;

    logic [NUM_PATIENTS-1:0] w_grant;
    logic [IW-1:0]       w_grantIdx;
    logic                w_any;
    logic                w_accept;
    logic                w_report;
    logic [CW-1:0]       w_updCount;

    rr_arbiter #(
        .N  (NUM_PATIENTS),
        .IW (IW)
    ) u_arbiter (
        .i_req   (sample_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grantIdx),
        .o_any   (w_any)
    );

    assign w_accept = (r_state == IDLE) && w_any;
    assign w_report = (r_state == REPORT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_any) w_nextState = EVAL;
            EVAL:    w_nextState = REPORT;
            REPORT:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The detector sees only registered fields, so sample_* never reaches det_* combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr            <= '0;
            r_grantIdx       <= '0;
            r_detPh          <= '0;
            r_detType        <= '0;
            r_resultAbnormal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grantIdx <= w_grantIdx;
                r_detPh    <= sample_ph[32'(w_grantIdx) * PH_W +: PH_W];
                r_detType  <= sample_type[32'(w_grantIdx) * TYPE_W +: TYPE_W];
                r_ptr      <= (w_grantIdx == IW'(NUM_PATIENTS - 1)) ? '0 : w_grantIdx + IW'(1);
            end
            if (r_state == EVAL) begin
                r_resultAbnormal <= det_abnormal;
            end
        end
    end

    always_comb begin
        w_updCount = '0;
        if (r_resultAbnormal) begin
            w_updCount = (r_streak[r_grantIdx] == CONF) ? CONF : r_streak[r_grantIdx] + CW'(1);
        end
    end

    // A confirming report beats a simultaneous clear; otherwise the clear restarts the streak from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm <= '0;
            for (int i = 0; i < NUM_PATIENTS; i++) begin
                r_streak[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PATIENTS; i++) begin
                if (w_report && (r_grantIdx == IW'(i))) begin
                    if (w_updCount == CONF) begin
                        r_streak[i] <= w_updCount;
                        r_alarm[i]  <= 1'b1;
                    end else if (alarm_clear[i]) begin
                        r_streak[i] <= CW'(r_resultAbnormal);
                        r_alarm[i]  <= 1'b0;
                    end else begin
                        r_streak[i] <= w_updCount;
                    end
                end else if (alarm_clear[i]) begin
                    r_streak[i] <= '0;
                    r_alarm[i]  <= 1'b0;
                end
            end
        end
    end

    assign sample_ready    = (r_state == IDLE) ? w_grant : '0;
    assign det_ph          = r_detPh;
    assign det_type        = r_detType;
    assign result_valid    = w_report;
    assign result_patient  = r_grantIdx;
    assign result_abnormal = r_resultAbnormal;
    assign alarm           = r_alarm;
    assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_blood_test_scheduler.sv
// Directed, table-driven bench for blood_test_scheduler with a simple pH-range detector model.
module tb_blood_test_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  sample_valid;
    logic [15:0] sample_ph;
    logic [11:0] sample_type;
    logic [3:0]  sample_ready;
    logic [3:0]  det_ph;
    logic [2:0]  det_type;
    logic        det_abnormal;
    logic        result_valid;
    logic [1:0]  result_patient;
    logic        result_abnormal;
    logic [3:0]  alarm;
    logic [3:0]  alarm_clear;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         patient;
        logic [3:0] ph;
        logic [2:0] ty;
        logic       expAbn;
        logic [3:0] expAlarm;
    } vec_t;

    vec_t vecs [12];

    blood_test_scheduler #(
        .NUM_PATIENTS  (4),
        .CONFIRM_COUNT (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_valid    (sample_valid),
        .sample_ph       (sample_ph),
        .sample_type     (sample_type),
        .sample_ready    (sample_ready),
        .det_ph          (det_ph),
        .det_type        (det_type),
        .det_abnormal    (det_abnormal),
        .result_valid    (result_valid),
        .result_patient  (result_patient),
        .result_abnormal (result_abnormal),
        .alarm           (alarm),
        .alarm_clear     (alarm_clear),
        .busy            (busy)
    );

    // Detector model: pH readings outside 3..9 are abnormal.
    assign det_abnormal = (det_ph >= 4'hA) || (det_ph <= 4'h2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serves one request starting from an IDLE negedge and returns at the following IDLE negedge.
    task automatic applyStimulus(input int p, input logic [3:0] ph, input logic [2:0] ty,
                                 input bit clr, input logic expAbn, input logic [3:0] expAlarm,
                                 input string tag);
        sample_ph[p*4 +: 4]   = ph;
        sample_type[p*3 +: 3] = ty;
        sample_valid          = 4'(1 << p);
        #1;
        checkOutput({tag, ".ready"}, 32'(sample_ready), 32'(1 << p));
        @(posedge clk);
        #1 sample_valid = 4'b0000;
        @(negedge clk);
        checkOutput({tag, ".evalBusy"}, 32'(busy), 32'd1);
        checkOutput({tag, ".detPh"}, 32'(det_ph), 32'(ph));
        checkOutput({tag, ".detType"}, 32'(det_type), 32'(ty));
        checkOutput({tag, ".evalReady"}, 32'(sample_ready), 32'd0);
        @(negedge clk);
        checkOutput({tag, ".resValid"}, 32'(result_valid), 32'd1);
        checkOutput({tag, ".resPatient"}, 32'(result_patient), 32'(p));
        checkOutput({tag, ".resAbn"}, 32'(result_abnormal), 32'(expAbn));
        if (clr) alarm_clear = 4'(1 << p);
        @(posedge clk);
        #1 alarm_clear = 4'b0000;
        @(negedge clk);
        checkOutput({tag, ".alarm"}, 32'(alarm), 32'(expAlarm));
        checkOutput({tag, ".idleValid"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2, 4'hF, 3'd1, 1'b1, 4'b0000};
        vecs[1]  = '{1, 4'hF, 3'd2, 1'b1, 4'b0000};
        vecs[2]  = '{1, 4'hB, 3'd3, 1'b1, 4'b0000};
        vecs[3]  = '{1, 4'hA, 3'd4, 1'b1, 4'b0010};
        vecs[4]  = '{1, 4'hF, 3'd5, 1'b1, 4'b0010};
        vecs[5]  = '{0, 4'hF, 3'd6, 1'b1, 4'b0010};
        vecs[6]  = '{0, 4'h0, 3'd7, 1'b1, 4'b0010};
        vecs[7]  = '{0, 4'h7, 3'd0, 1'b0, 4'b0010};
        vecs[8]  = '{0, 4'hC, 3'd1, 1'b1, 4'b0010};
        vecs[9]  = '{0, 4'hD, 3'd2, 1'b1, 4'b0010};
        vecs[10] = '{3, 4'hF, 3'd3, 1'b1, 4'b0010};
        vecs[11] = '{3, 4'hE, 3'd4, 1'b1, 4'b0010};

        rst          = 1'b1;
        sample_valid = '0;
        sample_ph    = '0;
        sample_type  = '0;
        alarm_clear  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.resValid", 32'(result_valid), 32'd0);
        checkOutput("reset.alarm", 32'(alarm), 32'd0);
        checkOutput("reset.detPh", 32'(det_ph), 32'd0);
        rst = 1'b0;

        // All four requesting continuously: round-robin from patient 0.
        sample_ph    = {4{4'h7}};
        sample_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("rr%0d.ready", k), 32'(sample_ready), 32'(1 << (k % 4)));
            checkOutput($sformatf("rr%0d.idleBusy", k), 32'(busy), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("rr%0d.evalBusy", k), 32'(busy), 32'd1);
            @(negedge clk);
            checkOutput($sformatf("rr%0d.resValid", k), 32'(result_valid), 32'd1);
            checkOutput($sformatf("rr%0d.resPatient", k), 32'(result_patient), 32'(k % 4));
            checkOutput($sformatf("rr%0d.resAbn", k), 32'(result_abnormal), 32'd0);
            if (k == 4) sample_valid = 4'b0000;
            @(negedge clk);
        end
        checkOutput("rr.alarm", 32'(alarm), 32'd0);

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].patient, vecs[v].ph, vecs[v].ty, 1'b0,
                          vecs[v].expAbn, vecs[v].expAlarm, $sformatf("vec%0d", v));
        end

        // Clear coinciding with a confirming report for patient 3: the set wins.
        applyStimulus(3, 4'hF, 3'd2, 1'b1, 1'b1, 4'b1010, "clrSetWins");
        alarm_clear = 4'b1010;
        @(posedge clk);
        #1 alarm_clear = 4'b0000;
        @(negedge clk);
        checkOutput("idleClear.alarm", 32'(alarm), 32'd0);
        applyStimulus(3, 4'hB, 3'd1, 1'b0, 1'b1, 4'b0000, "p3After1");
        applyStimulus(3, 4'hA, 3'd1, 1'b0, 1'b1, 4'b0000, "p3After2");

        // Clear with a non-confirming abnormal report leaves the streak at 1.
        applyStimulus(2, 4'hF, 3'd0, 1'b1, 1'b1, 4'b0000, "p2ClrAbn");
        applyStimulus(2, 4'hF, 3'd0, 1'b0, 1'b1, 4'b0000, "p2Streak2");
        applyStimulus(2, 4'hF, 3'd0, 1'b0, 1'b1, 4'b0100, "p2Streak3");

        // Reset during EVAL aborts the sample and restores the pointer.
        sample_ph[7:4] = 4'h9;
        sample_valid   = 4'b0010;
        @(posedge clk);
        #1 sample_valid = 4'b0000;
        @(negedge clk);
        checkOutput("midRst.evalBusy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRst.busy", 32'(busy), 32'd0);
        checkOutput("midRst.resValid", 32'(result_valid), 32'd0);
        checkOutput("midRst.ready", 32'(sample_ready), 32'd0);
        checkOutput("midRst.alarm", 32'(alarm), 32'd0);
        checkOutput("midRst.detPh", 32'(det_ph), 32'd0);
        checkOutput("midRst.detType", 32'(det_type), 32'd0);
        checkOutput("midRst.resPatient", 32'(result_patient), 32'd0);
        checkOutput("midRst.resAbn", 32'(result_abnormal), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("midRst.quiet%0d", c), 32'(result_valid), 32'd0);
        end
        sample_valid = 4'b1010;
        #1;
        checkOutput("midRst.ptrGrant", 32'(sample_ready), 32'b0010);
        @(posedge clk);
        #1 sample_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midRst.resPatient1", 32'(result_patient), 32'd1);
        checkOutput("midRst.resValid1", 32'(result_valid), 32'd1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
